// File: rtl/slot_mask_decoder_pkg.sv
// Shared sizing, FSM state encoding and index-to-one-hot helper for the slot mask decoder.
package slot_mask_decoder_pkg;

  localparam int   SLOTS     = 5;
  localparam int   IDX_WIDTH = 3;
  localparam int   CNT_WIDTH = 3;
  localparam logic ACTIVE    = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_t;

  // Out-of-range indices decode to all zeros.
  function automatic logic [SLOTS-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
    logic [SLOTS-1:0] r;
    r = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (int'(idx) == i) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/slot_mask_decoder_if.sv
// Request/response bundle between the object-slot allocator logic and the mask decoder.
interface slot_mask_decoder_if;
  import slot_mask_decoder_pkg::*;

  // A request transfers on a cycle where valid and ready are both high; ready depends only on
  // decoder state, never on valid, and a request not accepted is simply dropped by the decoder.
  logic                 set_valid;
  logic [IDX_WIDTH-1:0] set_idx;
  logic                 set_ready;
  logic                 clr_valid;
  logic [IDX_WIDTH-1:0] clr_idx;
  logic                 clr_ready;
  logic                 clr_all;
  logic                 frame_tick;
  logic [SLOTS-1:0]     free_mask;
  logic [SLOTS-1:0]     occ;
  logic [SLOTS-1:0]     spawn_pulse;
  logic [CNT_WIDTH-1:0] occ_count;
  logic                 err_range;
  logic                 err_dup;
  state_t               dbg_state;

  modport master (
    output set_valid, set_idx, clr_valid, clr_idx, clr_all, frame_tick,
    input  set_ready, clr_ready, free_mask, occ, spawn_pulse, occ_count,
    input  err_range, err_dup, dbg_state
  );

  modport slave (
    input  set_valid, set_idx, clr_valid, clr_idx, clr_all, frame_tick,
    output set_ready, clr_ready, free_mask, occ, spawn_pulse, occ_count,
    output err_range, err_dup, dbg_state
  );

endinterface

// File: rtl/slot_idx_decoder.sv
// Combinational slot index to one-hot decode with a range flag.
module slot_idx_decoder
  import slot_mask_decoder_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] idx,
  output logic [SLOTS-1:0]     oh,
  output logic                 in_range
);

  assign oh       = onehot(idx);
  assign in_range = (int'(idx) < SLOTS);

endmodule

// File: rtl/slot_mask_decoder.sv
// Stages spawn/despawn requests per frame and commits them atomically on frame_tick,
// publishing the occupancy and free mask consumed by the slot priority encoder.
module slot_mask_decoder
  import slot_mask_decoder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  slot_mask_decoder_if.slave  bus
);

  function automatic logic [CNT_WIDTH-1:0] popcount(input logic [SLOTS-1:0] v);
    logic [CNT_WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < SLOTS; i++) c = c + CNT_WIDTH'(v[i]);
    return c;
  endfunction

  state_t               state_q, state_d;
  logic [SLOTS-1:0]     occ_q, occ_d;
  logic [SLOTS-1:0]     pend_set_q, pend_set_d;
  logic [SLOTS-1:0]     pend_clr_q, pend_clr_d;
  logic [SLOTS-1:0]     spawn_q, spawn_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_range_q, err_range_d;
  logic                 err_dup_q, err_dup_d;

  logic [SLOTS-1:0] set_oh, clr_oh, taken;
  logic             set_in_range, clr_in_range;
  logic             idle, set_acc, clr_acc, set_dup;

  slot_idx_decoder u_set_dec (.idx(bus.set_idx), .oh(set_oh), .in_range(set_in_range));
  slot_idx_decoder u_clr_dec (.idx(bus.clr_idx), .oh(clr_oh), .in_range(clr_in_range));

  assign idle    = (state_q == ST_IDLE);
  assign set_acc = bus.set_valid & idle;
  assign clr_acc = bus.clr_valid & idle;
  assign taken   = occ_q | pend_set_q;
  // A slot already staged for clearing may be re-requested; the clear still wins at commit.
  assign set_dup = |(set_oh & taken & ~pend_clr_q);

  always_comb begin
    state_d     = state_q;
    occ_d       = occ_q;
    pend_set_d  = pend_set_q;
    pend_clr_d  = pend_clr_q;
    spawn_d     = '0;
    cnt_d       = cnt_q;
    err_range_d = 1'b0;
    err_dup_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (set_acc) begin
          if (!set_in_range)  err_range_d = 1'b1;
          else if (set_dup)   err_dup_d   = 1'b1;
          else                pend_set_d  = pend_set_q | set_oh;
        end
        if (clr_acc) begin
          if (!clr_in_range)  err_range_d = 1'b1;
          else                pend_clr_d  = pend_clr_d | clr_oh;
        end
        if (bus.clr_all)    pend_clr_d = '1;
        if (bus.frame_tick) state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        occ_d      = (occ_q & ~pend_clr_q) | (pend_set_q & ~pend_clr_q);
        spawn_d    = pend_set_q & ~pend_clr_q & ~occ_q;
        cnt_d      = popcount(occ_d);
        pend_set_d = '0;
        pend_clr_d = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      occ_q       <= '0;
      pend_set_q  <= '0;
      pend_clr_q  <= '0;
      spawn_q     <= '0;
      cnt_q       <= '0;
      err_range_q <= 1'b0;
      err_dup_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      pend_set_q  <= pend_set_d;
      pend_clr_q  <= pend_clr_d;
      spawn_q     <= spawn_d;
      cnt_q       <= cnt_d;
      err_range_q <= err_range_d;
      err_dup_q   <= err_dup_d;
    end
  end

  assign bus.set_ready   = idle;
  assign bus.clr_ready   = idle;
  assign bus.free_mask   = (ACTIVE == 1'b1) ? ~taken : taken;
  assign bus.occ         = occ_q;
  assign bus.spawn_pulse = spawn_q;
  assign bus.occ_count   = cnt_q;
  assign bus.err_range   = err_range_q;
  assign bus.err_dup     = err_dup_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_slot_mask_decoder.sv
// Bench for slot_mask_decoder: directed frame scenarios plus random traffic, checked by a
// frame-level slot model through an expected-output queue and a negedge monitor.
module tb_slot_mask_decoder;
  import slot_mask_decoder_pkg::*;

  localparam int W = 3 * SLOTS + CNT_WIDTH + 3;

  logic clk;
  logic rst;
  slot_mask_decoder_if bus();

  slot_mask_decoder dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  // Model state: per-slot flags, plus whether a commit cycle comes next.
  bit m_occ[SLOTS];
  bit m_pset[SLOTS];
  bit m_pclr[SLOTS];
  bit m_commit;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_step();
    logic [SLOTS-1:0] spawn, free_m, occ_m;
    logic er, ed;
    int si, ci, cnt;
    bit nv;
    spawn = '0; er = 1'b0; ed = 1'b0;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        m_occ[i] = 0; m_pset[i] = 0; m_pclr[i] = 0;
      end
      m_commit = 0;
    end else if (m_commit) begin
      for (int i = 0; i < SLOTS; i++) begin
        nv = !m_pclr[i] && (m_occ[i] || m_pset[i]);
        spawn[i] = nv && !m_occ[i];
        m_occ[i] = nv; m_pset[i] = 0; m_pclr[i] = 0;
      end
      m_commit = 0;
    end else begin
      if (bus.set_valid) begin
        si = int'(bus.set_idx);
        if (si >= SLOTS) er = 1'b1;
        else if ((m_occ[si] || m_pset[si]) && !m_pclr[si]) ed = 1'b1;
        else m_pset[si] = 1;
      end
      if (bus.clr_valid) begin
        ci = int'(bus.clr_idx);
        if (ci >= SLOTS) er = 1'b1;
        else m_pclr[ci] = 1;
      end
      if (bus.clr_all) for (int i = 0; i < SLOTS; i++) m_pclr[i] = 1;
      if (bus.frame_tick) m_commit = 1;
    end
    cnt = 0;
    for (int i = 0; i < SLOTS; i++) begin
      occ_m[i]  = m_occ[i];
      free_m[i] = (m_occ[i] || m_pset[i]) ? ~ACTIVE : ACTIVE;
      cnt += m_occ[i] ? 1 : 0;
    end
    exp_q.push_back({free_m, occ_m, spawn, CNT_WIDTH'(cnt), er, ed, ~m_commit});
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    rst = 1'b0;
    bus.set_valid = 1'b0; bus.set_idx = '0;
    bus.clr_valid = 1'b0; bus.clr_idx = '0;
    bus.clr_all = 1'b0;   bus.frame_tick = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    idle_inputs();
  endtask

  task automatic do_set(input int idx);
    bus.set_valid = 1'b1; bus.set_idx = IDX_WIDTH'(idx); cycle();
  endtask
  task automatic do_tick();
    bus.frame_tick = 1'b1; cycle();
  endtask
  task automatic do_rst();
    rst = 1'b1; cycle();
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("free_mask",   32'(bus.free_mask),   32'(e[W-1 -: SLOTS]));
        chk("occ",         32'(bus.occ),         32'(e[W-1-SLOTS -: SLOTS]));
        chk("spawn_pulse", 32'(bus.spawn_pulse), 32'(e[W-1-2*SLOTS -: SLOTS]));
        chk("occ_count",   32'(bus.occ_count),   32'(e[CNT_WIDTH+2 -: CNT_WIDTH]));
        chk("err_range",   32'(bus.err_range),   32'(e[2]));
        chk("err_dup",     32'(bus.err_dup),     32'(e[1]));
        chk("set_ready",   32'(bus.set_ready),   32'(e[0]));
        chk("clr_ready",   32'(bus.clr_ready),   32'(e[0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    m_commit = 0;
    do_rst(); do_rst();
    chk("reset_occ", 32'(bus.occ), 32'h0);
    chk("reset_ready", 32'(bus.set_ready), 32'h1);

    // 1: single spawn
    do_set(2); do_tick();
    chk("t1_ready_in_commit", 32'(bus.set_ready), 32'h0);
    cycle();
    chk("t1_occ", 32'(bus.occ), 32'h04);
    chk("t1_spawn", 32'(bus.spawn_pulse), 32'h04);
    chk("t1_count", 32'(bus.occ_count), 32'h1);
    cycle();
    chk("t1_spawn_gone", 32'(bus.spawn_pulse), 32'h0);

    // 2: duplicate set in one frame
    do_rst();
    do_set(0); do_set(0);
    chk("t2_err_dup", 32'(bus.err_dup), 32'h1);
    cycle();
    chk("t2_err_dup_pulse", 32'(bus.err_dup), 32'h0);
    do_tick(); cycle();
    chk("t2_occ", 32'(bus.occ), 32'h01);
    chk("t2_count", 32'(bus.occ_count), 32'h1);

    // 3: set and clear of the same slot in one cycle, clear wins
    do_rst();
    do_set(1); do_set(2); do_tick(); cycle();
    chk("t3_occ_pre", 32'(bus.occ), 32'h06);
    bus.set_valid = 1'b1; bus.set_idx = 3'd3;
    bus.clr_valid = 1'b1; bus.clr_idx = 3'd3;
    cycle();
    do_tick(); cycle();
    chk("t3_occ", 32'(bus.occ), 32'h06);
    chk("t3_spawn", 32'(bus.spawn_pulse), 32'h0);

    // 4: out-of-range index
    do_set(6);
    chk("t4_err_range", 32'(bus.err_range), 32'h1);
    do_tick(); cycle();
    chk("t4_occ", 32'(bus.occ), 32'h06);

    // 5: fill, reject, clear all
    do_rst();
    for (int i = 0; i < SLOTS; i++) do_set(i);
    do_tick(); cycle();
    chk("t5_free_full", 32'(bus.free_mask), 32'h1f);
    chk("t5_count_full", 32'(bus.occ_count), 32'h5);
    do_set(4);
    chk("t5_err_dup", 32'(bus.err_dup), 32'h1);
    bus.clr_all = 1'b1; cycle();
    chk("t5_pending_clr_not_free", 32'(bus.free_mask), 32'h1f);
    do_tick(); cycle();
    chk("t5_occ_empty", 32'(bus.occ), 32'h0);
    chk("t5_count_empty", 32'(bus.occ_count), 32'h0);

    // 6: reset during commit discards it
    do_set(1); do_tick();
    do_rst();
    chk("t6_occ", 32'(bus.occ), 32'h0);
    chk("t6_spawn", 32'(bus.spawn_pulse), 32'h0);
    chk("t6_ready", 32'(bus.set_ready), 32'h1);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.set_valid  = 1'($urandom_range(0, 1));
      bus.set_idx    = IDX_WIDTH'($urandom_range(0, 7));
      bus.clr_valid  = ($urandom_range(0, 3) == 0);
      bus.clr_idx    = IDX_WIDTH'($urandom_range(0, 7));
      bus.clr_all    = ($urandom_range(0, 39) == 0);
      bus.frame_tick = ($urandom_range(0, 4) == 0);
      cycle();
    end
    cycle(); cycle();
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
